ber_checker: RTL

BER_CHECKER -- requirements
Module: ber_checker

---
 rtl/ber_pkg.sv | 38 +++
 rtl/ber_ref_delay.sv | 45 ++++
 rtl/ber_checker.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/ber_pkg.sv
// ber_pkg
//   Shared definitions for the PRBS bit-error-rate checker:
//   - FSM state encoding (FILL -> SEARCH -> LOCK)
//   - default delay-line depth / window length / lock thresholds
//   - counter width constants
//   - tap increment helper with wrap at the delay-line depth
package ber_pkg;

  typedef enum logic [1:0] {
    ST_FILL   = 2'd0,
    ST_SEARCH = 2'd1,
    ST_LOCK   = 2'd2
  } ber_state_t;

  // One PRBS9 period: delay-line depth, search range and window length.
  localparam int unsigned SR_LEN_DEF         = 511;
  localparam int unsigned WIN_LEN_DEF        = 511;
  localparam int unsigned LOCK_ERR_MAX_DEF   = 10;
  localparam int unsigned UNLOCK_ERR_MIN_DEF = 128;

  // Counter widths.
  localparam int unsigned LAT_W     = 9;   // delay tap L and fill counter
  localparam int unsigned WIN_CNT_W = 9;   // symbols within a window
  localparam int unsigned WIN_ERR_W = 10;  // errors within a window
  localparam int unsigned ACC_W     = 64;  // long-term accumulators

  // Next tap in the search order; the last tap of the delay line wraps to 0.
  function automatic logic [LAT_W-1:0] tap_wrap_inc(
    input logic [LAT_W-1:0] tap,
    input int unsigned      depth
  );
    if (32'(tap) >= depth - 1) begin
      return '0;
    end
    return tap + 1'b1;
  endfunction

endpackage

// File: rtl/ber_ref_delay.sv
// ber_ref_delay
//   Reference delay line for the BER checker. Shifts the transmitted
//   reference bit in on every strobe and offers a tap-selected read of the
//   line as it stands before the shift, i.e. tap k returns the reference
//   bit from k+1 strobes earlier.
//
// Ports
//   clk      system clock, rising edge
//   reset    synchronous active-high clear of the line
//   enable   symbol strobe; the line shifts only when high
//   ref_bit  transmitted reference bit shifted in on a strobe
//   tap      tap select (0 .. SR_LEN-1)
//   tap_bit  reference bit at the selected tap (combinational read)
module ber_ref_delay
  import ber_pkg::*;
#(
  parameter int unsigned SR_LEN = SR_LEN_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             ref_bit,
  input  logic [LAT_W-1:0] tap,
  output logic             tap_bit
);

  logic [SR_LEN-1:0] sr;

  always_ff @(posedge clk) begin
    if (reset) begin
      sr <= '0;
    end else if (enable) begin
      sr <= {sr[SR_LEN-2:0], ref_bit};
    end
  end

  // Taps past the end of the line read as 0 rather than X.
  always_comb begin
    tap_bit = 1'b0;
    if (32'(tap) < SR_LEN) begin
      tap_bit = sr[tap];
    end
  end

endmodule

// File: rtl/ber_checker.sv
// ber_checker
//   PRBS bit-error-rate checker. After filling the reference delay line it
//   searches for the tap L at which the received stream matches the delayed
//   reference, evaluating one tap per window of WIN_LEN symbols. Once a
//   window shows at most LOCK_ERR_MAX errors the checker locks and
//   accumulates compared bits and bit errors; a locked window with at least
//   UNLOCK_ERR_MIN errors drops back to searching from the next tap.
//
// Ports
//   clk          system clock, rising edge
//   i_reset      synchronous active-high reset, priority over i_enable
//   i_enable     symbol strobe; all state holds when low
//   i_ref_bit    transmitted PRBS bit
//   i_rx_bit     sliced received bit
//   o_locked     high while in LOCK
//   o_latency    selected delay tap L
//   o_err_count  saturating count of bit errors seen while locked
//   o_bit_count  saturating count of bits compared while locked
module ber_checker
  import ber_pkg::*;
#(
  parameter int unsigned SR_LEN         = SR_LEN_DEF,
  parameter int unsigned WIN_LEN        = WIN_LEN_DEF,
  parameter int unsigned LOCK_ERR_MAX   = LOCK_ERR_MAX_DEF,
  parameter int unsigned UNLOCK_ERR_MIN = UNLOCK_ERR_MIN_DEF
) (
  input  logic             clk,
  input  logic             i_reset,
  input  logic             i_enable,
  input  logic             i_ref_bit,
  input  logic             i_rx_bit,
  output logic             o_locked,
  output logic [LAT_W-1:0] o_latency,
  output logic [ACC_W-1:0] o_err_count,
  output logic [ACC_W-1:0] o_bit_count
);

  ber_state_t           state;
  logic [LAT_W-1:0]     fill_cnt;
  logic [LAT_W-1:0]     lat;
  logic [WIN_CNT_W-1:0] win_cnt;
  logic [WIN_ERR_W-1:0] win_err;

  logic                 cmp_bit;
  logic                 bit_err;
  logic [WIN_ERR_W-1:0] win_err_next;
  logic                 win_end;
  logic                 fill_done;
  logic                 lock_ok;
  logic                 unlock_hit;
  logic [LAT_W-1:0]     lat_next_tap;

  // Compare bit is the pre-shift tap, i.e. the reference from L+1 strobes ago.
  ber_ref_delay #(
    .SR_LEN (SR_LEN)
  ) u_ref_delay (
    .clk     (clk),
    .reset   (i_reset),
    .enable  (i_enable),
    .ref_bit (i_ref_bit),
    .tap     (lat),
    .tap_bit (cmp_bit)
  );

  // Window decisions include the error of the strobe that ends the window.
  always_comb begin
    bit_err      = i_rx_bit ^ cmp_bit;
    win_err_next = win_err + WIN_ERR_W'(bit_err);
    win_end      = (32'(win_cnt) == WIN_LEN - 1);
    fill_done    = (32'(fill_cnt) == SR_LEN - 1);
    lock_ok      = (32'(win_err_next) <= LOCK_ERR_MAX);
    unlock_hit   = (32'(win_err_next) >= UNLOCK_ERR_MIN);
    lat_next_tap = tap_wrap_inc(lat, SR_LEN);
  end

  always_ff @(posedge clk) begin
    if (i_reset) begin
      state       <= ST_FILL;
      fill_cnt    <= '0;
      lat         <= '0;
      win_cnt     <= '0;
      win_err     <= '0;
      o_locked    <= 1'b0;
      o_err_count <= '0;
      o_bit_count <= '0;
    end else if (i_enable) begin
      case (state)
        ST_FILL: begin
          if (fill_done) begin
            state    <= ST_SEARCH;
            fill_cnt <= '0;
            lat      <= '0;
            win_cnt  <= '0;
            win_err  <= '0;
          end else begin
            fill_cnt <= fill_cnt + 1'b1;
          end
        end

        ST_SEARCH: begin
          if (win_end) begin
            win_cnt <= '0;
            win_err <= '0;
            if (lock_ok) begin
              state    <= ST_LOCK;
              o_locked <= 1'b1;
            end else begin
              lat <= lat_next_tap;
            end
          end else begin
            win_cnt <= win_cnt + 1'b1;
            win_err <= win_err_next;
          end
        end

        ST_LOCK: begin
          if (o_bit_count != '1) begin
            o_bit_count <= o_bit_count + 1'b1;
          end
          if (bit_err && (o_err_count != '1)) begin
            o_err_count <= o_err_count + 1'b1;
          end
          if (win_end) begin
            win_cnt <= '0;
            win_err <= '0;
            if (unlock_hit) begin
              state    <= ST_SEARCH;
              o_locked <= 1'b0;
              lat      <= lat_next_tap;
            end
          end else begin
            win_cnt <= win_cnt + 1'b1;
            win_err <= win_err_next;
          end
        end

        default: begin
          state    <= ST_FILL;
          fill_cnt <= '0;
          o_locked <= 1'b0;
        end
      endcase
    end
  end

  assign o_latency = lat;

endmodule
